// File: rtl/pwm_deadtime_if.sv
// Bus bundle between a PWM source / register block and the dead-time generator.
// With PWM_DT_FAULT_EN defined the bundle also carries the fault trip, clear and flag.
interface pwm_deadtime_if #(
    parameter int unsigned DT_W = 8
);
    logic            enable;
    logic [DT_W-1:0] dead_time;
    logic            pwm_in;
    logic            out_hi;
    logic            out_lo;
    logic            dt_active;
`ifdef PWM_DT_FAULT_EN
    logic            fault_in;
    logic            fault_clear;
    logic            fault_flag;

    modport master (
        output enable, dead_time, pwm_in, fault_in, fault_clear,
        input  out_hi, out_lo, dt_active, fault_flag
    );

    modport slave (
        input  enable, dead_time, pwm_in, fault_in, fault_clear,
        output out_hi, out_lo, dt_active, fault_flag
    );
`else
    modport master (
        output enable, dead_time, pwm_in,
        input  out_hi, out_lo, dt_active
    );

    modport slave (
        input  enable, dead_time, pwm_in,
        output out_hi, out_lo, dt_active
    );
`endif
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary dead-time generator: splits one PWM waveform into high/low-side gate
// drives separated by a programmable both-low band. Outputs are decoded from the next
// state and registered so they move on the same edge as the state.
// Optional macro PWM_DT_FAULT_EN adds a sticky external fault trip (FAULT state).
module pwm_deadtime #(
    parameter int unsigned DT_W = 8
) (
    input  logic          sys_clk,
    input  logic          sys_reset,
    pwm_deadtime_if.slave bus
);

`ifdef PWM_DT_FAULT_EN
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_HI_ON = 3'd1,
        ST_LO_ON = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_HI_ON = 2'd1,
        ST_LO_ON = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_nxt;
    logic [DT_W-1:0] dt_load;
    logic            out_hi_c;
    logic            out_lo_c;
    logic            dt_active_c;
`ifdef PWM_DT_FAULT_EN
    logic            fault_flag_nxt;
`endif

    // A programmed band of zero still yields a one-cycle band.
    assign dt_load = (bus.dead_time == '0) ? DT_W'(1) : bus.dead_time;

    // State and band counter register.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state <= ST_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter logic; fault beats enable, enable beats normal sequencing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef PWM_DT_FAULT_EN
        fault_flag_nxt = bus.fault_flag;
        if (bus.fault_in) begin
            state_nxt      = ST_FAULT;
            cnt_nxt        = '0;
            fault_flag_nxt = 1'b1;
        end else if (state == ST_FAULT) begin
            if (bus.fault_clear) begin
                state_nxt      = ST_OFF;
                fault_flag_nxt = 1'b0;
            end
        end else
`endif
        if (!bus.enable) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = ST_DEAD;
                    cnt_nxt   = dt_load;
                end
                ST_HI_ON: begin
                    if (!bus.pwm_in) begin
                        state_nxt = ST_DEAD;
                        cnt_nxt   = dt_load;
                    end
                end
                ST_LO_ON: begin
                    if (bus.pwm_in) begin
                        state_nxt = ST_DEAD;
                        cnt_nxt   = dt_load;
                    end
                end
                ST_DEAD: begin
                    if (cnt > DT_W'(1)) begin
                        cnt_nxt = cnt - DT_W'(1);
                    end else begin
                        state_nxt = bus.pwm_in ? ST_HI_ON : ST_LO_ON;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state; at most one gate can be selected.
    always_comb begin
        out_hi_c    = 1'b0;
        out_lo_c    = 1'b0;
        dt_active_c = 1'b0;
        case (state_nxt)
            ST_HI_ON: out_hi_c    = 1'b1;
            ST_LO_ON: out_lo_c    = 1'b1;
            ST_DEAD:  dt_active_c = 1'b1;
            default:  ;
        endcase
    end

    // Registered gate drives and band indicator.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            bus.out_hi    <= 1'b0;
            bus.out_lo    <= 1'b0;
            bus.dt_active <= 1'b0;
        end else begin
            bus.out_hi    <= out_hi_c;
            bus.out_lo    <= out_lo_c;
            bus.dt_active <= dt_active_c;
        end
    end

`ifdef PWM_DT_FAULT_EN
    // Sticky fault status, cleared only when the block leaves FAULT.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            bus.fault_flag <= 1'b0;
        end else begin
            bus.fault_flag <= fault_flag_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: directed scenarios plus randomized PWM/enable traffic,
// checked against a cycle-indexed reference model. Honours PWM_DT_FAULT_EN if defined.
module tb_pwm_deadtime;

    localparam int unsigned DT_W = 8;

    typedef struct {
        bit hi;
        bit lo;
        bit dt;
        bit flag;
    } exp_t;

    logic sys_clk;
    logic sys_reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    pwm_deadtime_if #(.DT_W(DT_W)) bus ();

    pwm_deadtime #(.DT_W(DT_W)) dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .bus       (bus.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Current stimulus values, applied at the next falling edge.
    bit       s_rst = 1'b1;
    bit       s_en  = 1'b0;
    int       s_dt  = 0;
    bit       s_pwm = 1'b0;
    bit       s_fi  = 1'b0;
    bit       s_fc  = 1'b0;

    // Reference model: band expressed as an absolute end cycle, gates as a chosen side.
    longint   cyc        = 0;
    bit       m_off      = 1'b1;
    bit       m_band     = 1'b0;
    longint   m_band_end = 0;
    bit       m_hi_side  = 1'b0;
    bit       m_fault    = 1'b0;
    bit       m_flag     = 1'b0;

    task automatic model_step();
        cyc++;
        if (s_rst) begin
            m_off = 1'b1; m_band = 1'b0; m_fault = 1'b0; m_flag = 1'b0;
        end else if (s_fi) begin
            m_fault = 1'b1; m_flag = 1'b1; m_off = 1'b1; m_band = 1'b0;
        end else if (m_fault) begin
            if (s_fc) begin
                m_fault = 1'b0; m_flag = 1'b0;
            end
        end else if (!s_en) begin
            m_off = 1'b1; m_band = 1'b0;
        end else if (m_band) begin
            if (cyc == m_band_end) begin
                m_band    = 1'b0;
                m_hi_side = s_pwm;
            end
        end else if (m_off || (m_hi_side != s_pwm)) begin
            m_off      = 1'b0;
            m_band     = 1'b1;
            m_band_end = cyc + ((s_dt == 0) ? 1 : s_dt);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge sys_clk);
        sys_reset     = s_rst;
        bus.enable    = s_en;
        bus.dead_time = DT_W'(s_dt);
        bus.pwm_in    = s_pwm;
`ifdef PWM_DT_FAULT_EN
        bus.fault_in    = s_fi;
        bus.fault_clear = s_fc;
`endif
        model_step();
        e.hi   = !m_off && !m_band && m_hi_side;
        e.lo   = !m_off && !m_band && !m_hi_side;
        e.dt   = m_band;
        e.flag = m_flag;
        exp_q.push_back(e);
    endtask

    task automatic run(input bit pwm, input int n);
        s_pwm = pwm;
        repeat (n) step();
    endtask

    task automatic check_bit(input string name, input bit act, input bit req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare one entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_bit("out_hi", bus.out_hi, e.hi);
                check_bit("out_lo", bus.out_lo, e.lo);
                check_bit("dt_active", bus.dt_active, e.dt);
                check_bit("no_overlap", bus.out_hi & bus.out_lo, 1'b0);
`ifdef PWM_DT_FAULT_EN
                check_bit("fault_flag", bus.fault_flag, e.flag);
`endif
            end
        end
    end

    // Global time limit so the bench always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int run_left;
        int en_hold;
        sys_reset     = 1'b1;
        bus.enable    = 1'b0;
        bus.dead_time = '0;
        bus.pwm_in    = 1'b0;
`ifdef PWM_DT_FAULT_EN
        bus.fault_in    = 1'b0;
        bus.fault_clear = 1'b0;
`endif
        // Reset with pwm and enable high.
        s_rst = 1'b1; s_en = 1'b1; s_dt = 4;
        run(1'b1, 2);
        s_rst = 1'b0;

        // Square wave 20/20 with a 4-cycle band.
        for (int p = 0; p < 3; p++) begin
            run(1'b1, 20);
            run(1'b0, 20);
        end

        // Zero dead time gives a 1-cycle band.
        s_dt = 0;
        for (int p = 0; p < 3; p++) begin
            run(1'b1, 6);
            run(1'b0, 6);
        end

        // Maximum dead time, no wrap.
        s_dt = 255;
        run(1'b1, 300);
        run(1'b0, 300);

        // Short high glitch during LO_ON is absorbed; dead_time change mid-band ignored.
        s_dt = 8;
        run(1'b0, 30);
        run(1'b1, 3);
        s_dt = 2;
        run(1'b0, 5);
        s_dt = 8;
        run(1'b0, 25);

        // Enable dropped mid-band, then re-enabled.
        s_dt = 10;
        run(1'b1, 4);
        s_en = 1'b0;
        run(1'b1, 3);
        s_en = 1'b1;
        run(1'b1, 20);
        run(1'b0, 20);

`ifdef PWM_DT_FAULT_EN
        // Fault during HI_ON; clear rejected while fault_in high; then clear.
        s_dt = 3;
        run(1'b1, 20);
        s_fi = 1'b1; run(1'b1, 1);
        s_fi = 1'b0; run(1'b1, 3);
        s_fi = 1'b1; s_fc = 1'b1; run(1'b1, 1);
        s_fi = 1'b0; s_fc = 1'b0; run(1'b1, 3);
        s_fc = 1'b1; run(1'b1, 1);
        s_fc = 1'b0; run(1'b1, 20);
`endif

        // Randomized traffic.
        run_left = 0;
        en_hold  = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                s_pwm    = ~s_pwm;
                run_left = $urandom_range(40, 1);
                if ($urandom_range(7, 0) == 0) s_dt = $urandom_range(255, 0);
                else                           s_dt = $urandom_range(12, 0);
            end
            run_left--;
            if (en_hold > 0) begin
                en_hold--;
                s_en = (en_hold != 0) ? 1'b0 : 1'b1;
            end else if ($urandom_range(79, 0) == 0) begin
                en_hold = $urandom_range(6, 1);
                s_en    = 1'b0;
            end
            s_rst = ($urandom_range(999, 0) == 0);
`ifdef PWM_DT_FAULT_EN
            s_fi = ($urandom_range(199, 0) == 0);
            s_fc = ($urandom_range(19, 0) == 0);
`endif
            step();
        end
        s_rst = 1'b0;
        s_fi  = 1'b0;
        s_fc  = 1'b0;
        s_en  = 1'b1;
        run(1'b1, 5);

        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge sys_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
